// File: rtl/apb4_wdg_cmd_master.sv
// APB4 initiator for key-unlocked peripherals: command port with optional unlock
// prefix write, plus an autonomous periodic keyed feeder for the watchdog.
module apb4_wdg_cmd_master #(
  parameter int unsigned                  ADDR_WIDTH   = 32,
  parameter int unsigned                  DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0]        BASE_ADDR    = '0,
  parameter logic [ADDR_WIDTH-1:0]        KEY_OFFS     = 'h14,
  parameter logic [ADDR_WIDTH-1:0]        FEED_OFFS    = 'h18,
  parameter logic [DATA_WIDTH-1:0]        KEY_VAL      = 32'h5F37_59DF,
  parameter int unsigned                  PERIOD_WIDTH = 24
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic                    cmd_keyed_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  output logic                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  input  logic                    feed_en_i,
  input  logic [PERIOD_WIDTH-1:0] feed_period_i,
  output logic                    feed_err_o,
  output logic                    feed_ovr_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [3:0]              pstrb_o,
  output logic [2:0]              pprot_o,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pready_i,
  input  logic                    pslverr_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_KSETUP, S_KACCESS, S_DSETUP, S_DACCESS, S_RESP
  } state_e;

  state_e                  state_q, state_d;
  logic                    write_q, write_d;
  logic                    feed_q, feed_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic                    pending_q, pending_d;
  logic                    ovr_q, ovr_d;
  logic                    run, expire, launch_feed;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      write_q   <= 1'b0;
      feed_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      feed_q    <= feed_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    feed_d      = feed_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    launch_feed = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          launch_feed = 1'b1;
          state_d     = S_KSETUP;
          feed_d      = 1'b1;
          write_d     = 1'b1;
          addr_d      = FEED_OFFS;
          wdata_d     = DATA_WIDTH'(1);
          rdata_d     = '0;
          err_d       = 1'b0;
        end else if (cmd_valid_i) begin
          state_d = cmd_keyed_i ? S_KSETUP : S_DSETUP;
          feed_d  = 1'b0;
          write_d = cmd_write_i;
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      S_KSETUP:  state_d = S_KACCESS;
      S_KACCESS: begin
        if (pready_i) begin
          if (pslverr_i) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_DSETUP;
          end
        end
      end
      S_DSETUP:  state_d = S_DACCESS;
      S_DACCESS: begin
        if (pready_i) begin
          err_d   = pslverr_i;
          if (!write_q) rdata_d = prdata_i;
          state_d = S_RESP;
        end
      end
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Expiry while a feed is still queued flags overrun instead of queuing twice.
  always_comb begin
    run       = feed_en_i && (feed_period_i != '0);
    expire    = run && (cnt_q == feed_period_i - PERIOD_WIDTH'(1));
    cnt_d     = (!run || expire) ? '0 : cnt_q + PERIOD_WIDTH'(1);
    ovr_d     = expire && pending_q;
    pending_d = expire ? 1'b1 : (launch_feed ? 1'b0 : pending_q);
  end

  always_comb begin
    cmd_ready_o = (state_q == S_IDLE) && !pending_q;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    feed_err_o  = 1'b0;
    feed_ovr_o  = ovr_q;
    paddr_o     = '0;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    pwrite_o    = 1'b0;
    pwdata_o    = '0;
    pstrb_o     = 4'h0;
    pprot_o     = 3'b000;
    unique case (state_q)
      S_KSETUP, S_KACCESS: begin
        psel_o    = 1'b1;
        penable_o = (state_q == S_KACCESS);
        paddr_o   = BASE_ADDR + KEY_OFFS;
        pwrite_o  = 1'b1;
        pwdata_o  = KEY_VAL;
        pstrb_o   = 4'hF;
      end
      S_DSETUP, S_DACCESS: begin
        psel_o    = 1'b1;
        penable_o = (state_q == S_DACCESS);
        paddr_o   = BASE_ADDR + addr_q;
        pwrite_o  = write_q;
        pwdata_o  = write_q ? wdata_q : '0;
        pstrb_o   = write_q ? 4'hF : 4'h0;
      end
      S_RESP: begin
        rsp_valid_o = !feed_q;
        rsp_rdata_o = feed_q ? '0 : rdata_q;
        rsp_err_o   = !feed_q && err_q;
        feed_err_o  = feed_q && err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_apb4_wdg_cmd_master.sv
// Bench for apb4_wdg_cmd_master: directed scenarios with literal expectations,
// then random traffic against a transfer-queue reference model.
module tb_apb4_wdg_cmd_master;

  localparam logic [31:0] KEY_ADDR = 32'h14;
  localparam logic [31:0] FEED_ADDR = 32'h18;
  localparam logic [31:0] KEY_V = 32'h5F37_59DF;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0, cmd_write_i = 1'b0, cmd_keyed_i = 1'b0;
  logic [31:0] cmd_addr_i = '0, cmd_wdata_i = '0;
  logic        cmd_ready_o, rsp_valid_o, rsp_err_o, feed_err_o, feed_ovr_o;
  logic [31:0] rsp_rdata_o;
  logic        feed_en_i = 1'b0;
  logic [23:0] feed_period_i = '0;
  logic [31:0] paddr_o, pwdata_o, prdata_i = '0;
  logic        psel_o, penable_o, pwrite_o;
  logic [3:0]  pstrb_o;
  logic [2:0]  pprot_o;
  logic        pready_i = 1'b1, pslverr_i = 1'b0;

  apb4_wdg_cmd_master dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write_i), .cmd_keyed_i(cmd_keyed_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .feed_en_i(feed_en_i), .feed_period_i(feed_period_i),
    .feed_err_o(feed_err_o), .feed_ovr_o(feed_ovr_o),
    .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .pprot_o(pprot_o), .prdata_i(prdata_i), .pready_i(pready_i),
    .pslverr_i(pslverr_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a command becomes a list of APB transfers; each transfer
  // is one setup cycle plus access cycles until pready, then a response cycle.
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    bit          key;
  } xfer_t;

  xfer_t       xq[$];
  bit          m_resp = 0, m_first = 0, m_feed = 0, m_err = 0;
  logic [31:0] m_rdata = '0;
  int unsigned m_cnt = 0;
  bit          m_pend = 0, m_ovr = 0;

  task automatic model_check();
    bit    ex_psel;
    xfer_t x;
    ex_psel = !m_resp && (xq.size() > 0);
    chk("cmd_ready", cmd_ready_o, !m_resp && xq.size() == 0 && !m_pend);
    chk("psel", psel_o, ex_psel);
    chk("pprot", pprot_o, 3'b000);
    chk("feed_ovr", feed_ovr_o, m_ovr);
    chk("feed_err", feed_err_o, m_resp && m_feed && m_err);
    chk("rsp_valid", rsp_valid_o, m_resp && !m_feed);
    if (ex_psel) begin
      x = xq[0];
      chk("penable", penable_o, !m_first);
      chk("paddr", paddr_o, x.addr);
      chk("pwrite", pwrite_o, x.wr);
      chk("pstrb", pstrb_o, x.wr ? 4'hF : 4'h0);
      if (x.wr) chk("pwdata", pwdata_o, x.wdata);
    end else begin
      chk("penable_idle", penable_o, 1'b0);
    end
    if (m_resp && !m_feed) begin
      chk("rsp_rdata", rsp_rdata_o, m_rdata);
      chk("rsp_err", rsp_err_o, m_err);
    end
  endtask

  task automatic model_step();
    bit    run, expire, launch;
    xfer_t x;
    if (rst_i) begin
      xq.delete();
      m_resp = 0; m_first = 0; m_feed = 0; m_err = 0; m_rdata = '0;
      m_cnt = 0; m_pend = 0; m_ovr = 0;
      return;
    end
    run    = feed_en_i && feed_period_i != 0;
    expire = run && (m_cnt == int'(feed_period_i) - 1);
    launch = !m_resp && xq.size() == 0 && m_pend;
    if (m_resp) begin
      m_resp = 0;
    end else if (xq.size() > 0) begin
      if (m_first) m_first = 0;
      else if (pready_i) begin
        x = xq.pop_front();
        if (x.key && pslverr_i) begin
          m_err = 1;
          xq.delete();
        end else if (!x.key) begin
          m_err = m_err | pslverr_i;
          if (!x.wr) m_rdata = prdata_i;
        end
        m_first = 1;
        if (xq.size() == 0) m_resp = 1;
      end
    end else if (m_pend || cmd_valid_i) begin
      m_feed = m_pend; m_err = 0; m_rdata = '0; m_first = 1;
      if (m_pend || cmd_keyed_i) xq.push_back('{KEY_ADDR, 1'b1, KEY_V, 1'b1});
      if (m_pend) xq.push_back('{FEED_ADDR, 1'b1, 32'h1, 1'b0});
      else xq.push_back('{cmd_addr_i, cmd_write_i, cmd_wdata_i, 1'b0});
    end
    m_ovr  = expire && m_pend;
    m_pend = expire ? 1'b1 : (launch ? 1'b0 : m_pend);
    m_cnt  = (!run || expire) ? 0 : m_cnt + 1;
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; cmd_valid_i = 1'b0; feed_en_i = 1'b0;
    pready_i = 1'b1; pslverr_i = 1'b0;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic set_cmd(input logic v, input logic wr, input logic k,
                         input logic [31:0] a, input logic [31:0] d);
    cmd_valid_i = v; cmd_write_i = wr; cmd_keyed_i = k;
    cmd_addr_i = a; cmd_wdata_i = d;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Unkeyed read
    prdata_i = 32'h5;
    chk("A_ready0", cmd_ready_o, 1'b1);
    for (int c = 0; c <= 4; c++) begin
      set_cmd(c == 0, 1'b0, 1'b0, 32'h0, 32'h0);
      if (c == 1) begin chk("A_psel1", psel_o, 1'b1); chk("A_pen1", penable_o, 1'b0); end
      if (c == 2) chk("A_pen2", penable_o, 1'b1);
      if (c == 3) begin
        chk("A_rsp3", rsp_valid_o, 1'b1);
        chk("A_rdata3", rsp_rdata_o, 32'h5);
        chk("A_err3", rsp_err_o, 1'b0);
      end
      if (c == 4) chk("A_ready4", cmd_ready_o, 1'b1);
      tick();
    end

    // Keyed write, back-to-back key and data transfers
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      set_cmd(c == 0, 1'b1, 1'b1, 32'h0, 32'h4);
      if (c >= 1 && c <= 4) chk("B_psel", psel_o, 1'b1);
      if (c == 1) begin chk("B_kaddr", paddr_o, 32'h14); chk("B_kdata", pwdata_o, 32'h5F3759DF); end
      if (c == 3) begin chk("B_daddr", paddr_o, 32'h0); chk("B_ddata", pwdata_o, 32'h4); end
      if (c == 5) begin chk("B_rsp5", rsp_valid_o, 1'b1); chk("B_psel5", psel_o, 1'b0); end
      tick();
    end

    // Wait states in key access
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      set_cmd(c == 0, 1'b1, 1'b1, 32'h8, 32'h9);
      pready_i = !(c >= 2 && c <= 4);
      if (c >= 2 && c <= 5) begin
        chk("C_kaddr", paddr_o, 32'h14);
        chk("C_kdata", pwdata_o, 32'h5F3759DF);
        chk("C_pen", penable_o, 1'b1);
      end
      if (c == 7) chk("C_rsp7", rsp_valid_o, 1'b0);
      if (c == 8) chk("C_rsp8", rsp_valid_o, 1'b1);
      tick();
    end

    // Key phase error aborts data phase
    do_reset();
    pslverr_i = 1'b1; prdata_i = 32'hDEAD_BEEF;
    for (int c = 0; c <= 3; c++) begin
      set_cmd(c == 0, 1'b0, 1'b1, 32'h8, 32'h0);
      if (c == 3) begin
        chk("D_rsp", rsp_valid_o, 1'b1);
        chk("D_err", rsp_err_o, 1'b1);
        chk("D_rdata", rsp_rdata_o, 32'h0);
        chk("D_psel", psel_o, 1'b0);
      end
      tick();
    end
    pslverr_i = 1'b0;

    // Auto-feed every 10 clocks, colliding command waits
    do_reset();
    feed_en_i = 1'b1; feed_period_i = 24'd10;
    for (int c = 0; c <= 20; c++) begin
      set_cmd(c >= 10 && c <= 16, 1'b1, 1'b0, 32'h4, 32'h7);
      if (c == 10) chk("E_ready10", cmd_ready_o, 1'b0);
      if (c == 11) begin chk("E_psel11", psel_o, 1'b1); chk("E_kaddr", paddr_o, 32'h14); end
      if (c == 13) begin chk("E_faddr", paddr_o, 32'h18); chk("E_fdata", pwdata_o, 32'h1); end
      if (c == 15) begin chk("E_norsp", rsp_valid_o, 1'b0); chk("E_psel15", psel_o, 1'b0); end
      if (c == 16) chk("E_ready16", cmd_ready_o, 1'b1);
      if (c == 17) begin chk("E_caddr", paddr_o, 32'h4); chk("E_cdata", pwdata_o, 32'h7); end
      if (c == 19) chk("E_rsp19", rsp_valid_o, 1'b1);
      tick();
    end

    // Short period with stalled bus produces overrun
    do_reset();
    feed_en_i = 1'b1; feed_period_i = 24'd2;
    for (int c = 0; c <= 20; c++) begin
      pready_i = !(c >= 4 && c <= 9);
      if (c == 5) chk("F_ovr5", feed_ovr_o, 1'b0);
      if (c == 6) chk("F_ovr6", feed_ovr_o, 1'b1);
      tick();
    end

    // Reset in the middle of an access
    do_reset();
    pready_i = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      set_cmd(c == 0, 1'b1, 1'b1, 32'h0, 32'h3);
      rst_i = (c == 2);
      if (c == 2) chk("G_psel2", psel_o, 1'b1);
      if (c == 3) chk("G_psel3", psel_o, 1'b0);
      if (c >= 3) chk("G_norsp", rsp_valid_o, 1'b0);
      tick();
    end
    rst_i = 1'b0;

    // Random traffic
    for (int seg = 0; seg < 12; seg++) begin
      feed_en_i = 1'b0;
      set_cmd(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      feed_en_i = ($urandom_range(0, 3) != 0);
      feed_period_i = 24'($urandom_range(0, 30));
      for (int c = 0; c < 250; c++) begin
        set_cmd($urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom),
                32'($urandom_range(0, 15) * 4), $urandom);
        pready_i  = ($urandom_range(0, 3) != 0);
        pslverr_i = ($urandom_range(0, 9) == 0);
        prdata_i  = $urandom;
        rst_i     = ($urandom_range(0, 299) == 0);
        tick();
      end
      rst_i = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
